// File: rtl/cla_operand_sequencer_if.sv
`default_nettype none
// ============================================================================
// cla_operand_sequencer_if : operand stream, adder hookup and result stream
// Revision 1.0
// ============================================================================
interface cla_operand_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] cla_a;
  logic [WIDTH-1:0] cla_b;
  logic             cla_cin;
  logic [WIDTH-1:0] cla_sum;
  logic             cla_cout;
  logic [WIDTH-1:0] out_sum;
  logic             out_carry;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;
  logic             out_valid;
  logic             out_ready;
  logic             busy;

  // Sequencer side
  modport master (
    input  in_data, in_valid, in_last, cla_sum, cla_cout, out_ready,
    output in_ready, cla_a, cla_b, cla_cin,
           out_sum, out_carry, out_last, out_idx, out_valid, busy
  );

  // Producer / adder / consumer side
  modport slave (
    output in_data, in_valid, in_last, cla_sum, cla_cout, out_ready,
    input  in_ready, cla_a, cla_b, cla_cin,
           out_sum, out_carry, out_last, out_idx, out_valid, busy
  );
endinterface
`default_nettype wire

// File: rtl/cla_operand_sequencer.sv
`default_nettype none
// ============================================================================
// cla_operand_sequencer : feeds A/B words to an external CLA and registers
// its sum; CLA_SEQ_CHAIN_EN chains carry across words (multi-precision).
// Revision 1.0
// ============================================================================
module cla_operand_sequencer #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 4
) (
  input  wire logic               clk,
  input  wire logic               rst,
  cla_operand_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    S_LOAD_A = 2'd0,
    S_LOAD_B = 2'd1,
    S_ADD    = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_last;
  logic [WIDTH-1:0] r_out_sum;
  logic             r_out_carry;
  logic             r_out_last;
  logic [IDX_W-1:0] r_out_idx;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_a_fire;
  logic             w_b_fire;
  logic             w_add;
  logic             w_res_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LOAD_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Handshake strobes are qualified by state only, so ready/valid never
  // depend combinationally on the partner's valid/ready.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_a_fire    = 1'b0;
    w_b_fire    = 1'b0;
    w_add       = 1'b0;
    w_res_fire  = 1'b0;
    case (r_state)
      S_LOAD_A: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_a_fire    = 1'b1;
          w_state_nxt = S_LOAD_B;
        end
      end
      S_LOAD_B: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_b_fire    = 1'b1;
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        w_add       = 1'b1;
        w_state_nxt = S_RESULT;
      end
      S_RESULT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_res_fire  = 1'b1;
          w_state_nxt = S_LOAD_A;
        end
      end
      default: w_state_nxt = S_LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_last      <= 1'b0;
      r_out_sum   <= '0;
      r_out_carry <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_idx   <= '0;
    end else begin
      if (w_a_fire) begin
        r_a <= bus.in_data;
      end
      if (w_b_fire) begin
        r_b    <= bus.in_data;
        r_last <= bus.in_last;
      end
      if (w_add) begin
        r_out_sum   <= bus.cla_sum;
        r_out_carry <= bus.cla_cout;
        r_out_last  <= r_last;
      end
      if (w_res_fire) begin
        r_out_idx <= r_out_last ? '0 : r_out_idx + IDX_W'(1);
      end
    end
  end

`ifdef CLA_SEQ_CHAIN_EN
  logic r_chain_carry;

  // Carry propagates only between words of one chain; the last word ends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain_carry <= 1'b0;
    end else if (w_res_fire) begin
      r_chain_carry <= r_out_last ? 1'b0 : r_out_carry;
    end
  end

  assign bus.cla_cin = r_chain_carry;
`else
  assign bus.cla_cin = 1'b0;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.busy      = (r_state != S_LOAD_A);
  assign bus.cla_a     = r_a;
  assign bus.cla_b     = r_b;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_carry = r_out_carry;
  assign bus.out_last  = r_out_last;
  assign bus.out_idx   = r_out_idx;

endmodule
`default_nettype wire

// File: tb/tb_cla_operand_sequencer.sv
`default_nettype none
// ============================================================================
// tb_cla_operand_sequencer : directed vectors against a behavioural CLA.
// Revision 1.0
// ============================================================================
module tb_cla_operand_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  cla_operand_sequencer_if #(.WIDTH(8), .IDX_W(4)) u_if ();

  // Stand-in for the tt_um_cla adder
  assign {u_if.cla_cout, u_if.cla_sum} =
      {1'b0, u_if.cla_a} + {1'b0, u_if.cla_b} + {8'd0, u_if.cla_cin};

  cla_operand_sequencer #(.WIDTH(8), .IDX_W(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.master)
  );

`ifdef CLA_SEQ_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One word: A beat, B beat, then check ADD/RESULT timing and values.
  task automatic run_word(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic last, input logic [7:0] e_sum,
                          input logic e_c, input logic [3:0] e_idx);
    int n = 0;
    while (!u_if.in_ready && n < 10) begin
      tick();
      n++;
    end
    chk({tag, "_in_ready"}, 32'(u_if.in_ready), 32'd1);
    u_if.in_valid = 1'b1;
    u_if.in_data  = a;
    tick();
    u_if.in_data  = b;
    u_if.in_last  = last;
    tick();
    u_if.in_valid  = 1'b0;
    u_if.in_last   = 1'b0;
    u_if.out_ready = 1'b1;
    chk({tag, "_add_valid"}, 32'(u_if.out_valid), 32'd0);
    chk({tag, "_add_ready"}, 32'(u_if.in_ready), 32'd0);
    tick();
    chk({tag, "_valid"}, 32'(u_if.out_valid), 32'd1);
    chk({tag, "_sum"},   32'(u_if.out_sum),   32'(e_sum));
    chk({tag, "_carry"}, 32'(u_if.out_carry), 32'(e_c));
    chk({tag, "_last"},  32'(u_if.out_last),  32'(last));
    chk({tag, "_idx"},   32'(u_if.out_idx),   32'(e_idx));
    chk({tag, "_busy"},  32'(u_if.busy),      32'd1);
    tick();
    u_if.out_ready = 1'b0;
    chk({tag, "_done"},  32'(u_if.in_ready),  32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.in_valid  = 1'b0;
    u_if.in_data   = '0;
    u_if.in_last   = 1'b0;
    u_if.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    chk("rst_in_ready",  32'(u_if.in_ready),  32'd1);
    chk("rst_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("rst_busy",      32'(u_if.busy),      32'd0);
    chk("rst_sum",       32'(u_if.out_sum),   32'd0);
    chk("rst_idx",       32'(u_if.out_idx),   32'd0);
    chk("rst_cin",       32'(u_if.cla_cin),   32'd0);

    run_word("single", 8'h3C, 8'h5A, 1'b1, 8'h96, 1'b0, 4'd0);

    run_word("chain0", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'd0);
    chk("chain_cin", 32'(u_if.cla_cin), CHAIN ? 32'd1 : 32'd0);
    run_word("chain1", 8'h00, 8'h00, 1'b1, CHAIN ? 8'h01 : 8'h00, 1'b0, 4'd1);
    chk("chain_cin_clr", 32'(u_if.cla_cin), 32'd0);
    run_word("chain2", 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, 4'd0);

    // Backpressure: result must hold while out_ready is low
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h10;
    tick();
    u_if.in_data  = 8'h20;
    u_if.in_last  = 1'b1;
    tick();
    u_if.in_valid = 1'b0;
    u_if.in_last  = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    32'(u_if.out_valid), 32'd1);
      chk("bp_in_ready", 32'(u_if.in_ready),  32'd0);
      chk("bp_sum",      32'(u_if.out_sum),   32'h30);
      chk("bp_carry",    32'(u_if.out_carry), 32'd0);
      chk("bp_last",     32'(u_if.out_last),  32'd1);
      tick();
    end
    u_if.out_ready = 1'b1;
    tick();
    u_if.out_ready = 1'b0;
    chk("bp_rel_ready", 32'(u_if.in_ready),  32'd1);
    chk("bp_rel_valid", 32'(u_if.out_valid), 32'd0);
    chk("bp_rel_busy",  32'(u_if.busy),      32'd0);

    // Reset while waiting for B discards the partial operand
    u_if.in_valid = 1'b1;
    u_if.in_data  = 8'h11;
    tick();
    u_if.in_valid = 1'b0;
    chk("mid_busy", 32'(u_if.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_in_ready",  32'(u_if.in_ready),  32'd1);
    chk("mid_out_valid", 32'(u_if.out_valid), 32'd0);
    chk("mid_cla_a",     32'(u_if.cla_a),     32'd0);
    chk("mid_sum",       32'(u_if.out_sum),   32'd0);
    chk("mid_last",      32'(u_if.out_last),  32'd0);
    run_word("post_rst", 8'h02, 8'h03, 1'b1, 8'h05, 1'b0, 4'd0);

    // Index wrap over 17 unterminated words
    for (int i = 0; i < 17; i++) begin
      run_word("wrap", 8'(i), 8'h01, 1'b0, 8'(i + 1), 1'b0, 4'(i));
    end
    run_word("wrap_last", 8'h05, 8'h05, 1'b1, 8'h0A, 1'b0, 4'd1);
    run_word("wrap_after", 8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cla_operand_sequencer.md
# cla_operand_sequencer

Sequencer that sits directly upstream of the `tt_um_cla` carry-lookahead adder. It accepts operand words over a single byte-wide valid/ready stream, presents them to the adder's combinational inputs, and registers the sum and carry into an output valid/ready stream. It optionally chains carry between consecutive words to form multi-precision additions.

## Interface
Parameters:
- `WIDTH`, 8, operand/sum width; must match the adder width.
- `IDX_W`, 4, width of the word-index counter.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_data`  in  WIDTH  operand word: A on first beat, B on second beat.
- `in_valid`  in  1  `in_data` and `in_last` valid.
- `in_last`  in  1  sampled on the B beat only; marks the final word of a chained operation.
- `in_ready`  out  1  sequencer accepts a beat this cycle.
- `cla_a`  out  WIDTH  registered operand A, to the adder.
- `cla_b`  out  WIDTH  registered operand B, to the adder.
- `cla_cin`  out  1  carry-in to the adder.
- `cla_sum`  in  WIDTH  adder sum, combinational from `cla_a`/`cla_b`/`cla_cin`.
- `cla_cout`  in  1  adder carry-out.
- `out_sum`  out  WIDTH  registered sum.
- `out_carry`  out  1  registered carry-out.
- `out_last`  out  1  `in_last` of this word.
- `out_idx`  out  IDX_W  word index within the current chain.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in every state except `LOAD_A`.

## Operation
- FSM states: `LOAD_A`, `LOAD_B`, `ADD`, `RESULT`.
- `LOAD_A`: `in_ready`=1. On `in_valid`, capture `in_data` into A and go to `LOAD_B`.
- `LOAD_B`: `in_ready`=1. On `in_valid`, capture `in_data` into B and `in_last` into the last register, then go to `ADD`.
- `ADD`: `in_ready`=0. Capture `cla_sum` into `out_sum` and `cla_cout` into `out_carry`, copy the last register to `out_last`, then go to `RESULT`.
- `RESULT`: `out_valid`=1, `in_ready`=0. All `out_*` registers are held stable until `out_ready`=1. On that handshake, go to `LOAD_A`, update the chain-carry register (see Configuration), and update the index:
  - `out_last`=1: index cleared to 0.
  - otherwise: index incremented modulo 2^IDX_W; wrap 15→0 has no other effect.
- `cla_a`/`cla_b` are driven from the A/B registers at all times. `cla_cin` is driven from the chain-carry register.
- `in_ready` and `out_valid` are decoded combinationally from the state register only; neither depends on `in_valid` or `out_ready`.
- Reset:
  - state=`LOAD_A`; A, B, last, `out_sum`, `out_carry`, `out_last`, `out_idx` and chain-carry all cleared to 0.
  - After reset: `in_ready`=1, `out_valid`=0, `busy`=0.
  - Reset asserted in any state discards partial operands and any pending result without producing output.
- Arithmetic: `out_sum` = (A + B + `cla_cin`) mod 2^WIDTH; `out_carry` = bit WIDTH of that sum. The sequencer only registers the adder's result and never recomputes it.

## Timing
- Cycle n: B accepted. Cycle n+1: `ADD`, result captured. Cycle n+2: `out_valid`=1.
- Minimum period is 4 cycles per word (A, B, ADD, RESULT with `out_ready`=1).
- No beat is accepted while in `ADD` or `RESULT`, so input and output handshakes never coincide.
- `out_ready` asserted before `out_valid` is permitted. The handshake completes on the first `RESULT` cycle.

## Configuration
- Macro `CLA_SEQ_CHAIN_EN`.
- Defined:
  - On the `RESULT` handshake, chain-carry ← `out_carry` if `out_last`=0, else 0.
  - `cla_cin` = chain-carry, so successive words form one multi-precision addition, least-significant word first.
- Undefined:
  - Chain-carry register is not built and `cla_cin` is tied to 0.
  - `in_last` is still captured and forwarded to `out_last`, and the `out_idx` behaviour is unchanged.

## Test plan
- Single add: A=0x3C, B=0x5A, `in_last`=1, `out_ready`=1 → `out_sum`=0x96, `out_carry`=0, `out_idx`=0, with `out_valid` exactly 2 cycles after the B beat.
- Chain (`CLA_SEQ_CHAIN_EN` defined): word0 0xFF+0x01 with last=0, then word1 0x00+0x00 with last=1 → (0x00, c=1, idx 0), then (0x01, c=0, idx 1). A following word 0x00+0x00 gives 0x00, proving chain-carry cleared.
- Same stimulus without `CLA_SEQ_CHAIN_EN` → (0x00, c=1, idx 0), then (0x00, c=0, idx 1).
- Backpressure: hold `out_ready`=0 for 5 cycles in `RESULT` → `out_valid`=1 and outputs unchanged throughout, `in_ready`=0 throughout; a single-cycle `out_ready` pulse returns to `LOAD_A`.
- Reset mid-operation: accept A=0x11, assert `rst` in `LOAD_B` → next cycle `in_ready`=1, `out_valid`=0, all outputs 0. A new 0x02+0x03 yields 0x05.
- Index wrap: 17 words with `in_last`=0 → `out_idx` reads 0..15, then 0. A word with `in_last`=1 resets the next index to 0.
